ram8_dump: RTL and testbench

Eight-word, 16-bit register bank with a built-in sequential dump engine. It is the storage stage that sits directly upstream of the 8-way 16-bit read multiplexer. Its eight registers drive the mux's `a`..`h` inputs, and the mux select comes from either the CPU read address or the dump pointer. The dump engine streams all eight words, in address order, out of a valid/ready port for debug and UART memory dumps. Normal reads and writes continue while a dump is in progress.

---
 rtl/ram8_dump.sv | 104 ++++++++++
 tb/tb_ram8_dump.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_dump.sv
// Eight-word register bank feeding the 8-way read mux,
// with a valid/ready engine that streams all words in address order.
module ram8_dump #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_data,
  output logic [2:0]       dump_addr,
  output logic             dump_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [8];
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic             hs;
  logic [WIDTH-1:0] cap_data;

  assign out = mem[address];
  assign hs  = dump_valid & dump_ready;

  // a write landing on the word being captured wins
  assign cap_data = (load && address == ptr) ? in : mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (load) begin
      mem[address] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      dump_data <= '0;
      dump_addr <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (state == LOAD) begin
        dump_data <= cap_data;
        dump_addr <= ptr;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          ptr_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        dump_busy = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (ptr == 3'd7) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt   = ptr + 3'd1;
            state_nxt = LOAD;
          end
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram8_dump.sv
// Directed bench for ram8_dump: storage, dump cadence,
// backpressure, writes during dump, ignored start, reset abort.
module tb_ram8_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] dump_data;
  logic [2:0]  dump_addr;
  logic        dump_done;

  int checks   = 0;
  int failures = 0;

  int          n_words;
  int          n_done;
  int          done_cyc;
  int          busy_cnt;
  logic        c1_busy;
  logic        c1_valid;
  logic [2:0]  got_addr [16];
  logic [15:0] got_data [16];
  int          got_cyc  [16];
  logic        hold_valid [8];
  logic [2:0]  hold_addr  [8];
  logic [15:0] hold_data  [8];
  int          wr_cyc [2];
  logic [2:0]  wr_a   [2];
  logic [15:0] wr_d   [2];
  int          extra_start;

  always #5 clk = ~clk;

  ram8_dump #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .load       (load),
    .address    (address),
    .out        (out),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_done  (dump_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hooks();
    wr_cyc[0]   = -1;
    wr_cyc[1]   = -1;
    extra_start = -1;
  endtask

  // stimulus and recording only; each test judges the record
  task automatic run_dump(input int stall_word, input int stall_len);
    int c;
    int stall;
    n_words  = 0;
    n_done   = 0;
    done_cyc = -1;
    busy_cnt = 0;
    stall    = 0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    c = 1;
    while (c < 80) begin
      load       = 1'b0;
      dump_ready = 1'b1;
      dump_start = (c == extra_start);
      for (int j = 0; j < 2; j++) begin
        if (wr_cyc[j] == c) begin
          load    = 1'b1;
          address = wr_a[j];
          in      = wr_d[j];
        end
      end
      if (c == 1) begin
        c1_busy  = dump_busy;
        c1_valid = dump_valid;
      end
      if (dump_valid && int'(dump_addr) == stall_word &&
          stall < stall_len) begin
        dump_ready        = 1'b0;
        hold_valid[stall] = dump_valid;
        hold_addr[stall]  = dump_addr;
        hold_data[stall]  = dump_data;
        stall++;
      end
      if (dump_valid && dump_ready && n_words < 16) begin
        got_addr[n_words] = dump_addr;
        got_data[n_words] = dump_data;
        got_cyc[n_words]  = c;
        n_words++;
      end
      if (dump_done) begin
        n_done++;
        done_cyc = c;
      end
      if (dump_busy) busy_cnt++;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      tick();
      c++;
    end
    load       = 1'b0;
    dump_start = 1'b0;
    dump_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in         = '0;
    load       = 1'b0;
    address    = '0;
    dump_start = 1'b0;
    dump_ready = 1'b1;
    clear_hooks();
    #12;
    checks++;
    if ({dump_busy, dump_valid, dump_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000",
               {dump_busy, dump_valid, dump_done});
    end
    checks++;
    if (dump_data !== 16'h0 || dump_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset_dump got=%h/%0d want=0000/0",
               dump_data, dump_addr);
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h0) begin
        failures++;
        $display("FAIL reset_out[%0d] got=%h want=0000", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      in      = 16'h1000 + 16'(i);
      load    = 1'b1;
      #1;
      checks++;
      if (out !== 16'h0) begin
        failures++;
        $display("FAIL wr_early[%0d] got=%h want=0000", i, out);
      end
      tick();
      load = 1'b0;
      checks++;
      if (out !== 16'h1000 + 16'(i)) begin
        failures++;
        $display("FAIL wr_next[%0d] got=%h want=%h",
                 i, out, 16'h1000 + 16'(i));
      end
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h1000 + 16'(i)) begin
        failures++;
        $display("FAIL sweep[%0d] got=%h want=%h",
                 i, out, 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_full_dump();
    clear_hooks();
    run_dump(-1, 0);
    checks++;
    if (c1_busy !== 1'b1 || c1_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_lat got busy=%b valid=%b want 1/0",
               c1_busy, c1_valid);
    end
    checks++;
    if (n_words != 8) begin
      failures++;
      $display("FAIL full_words got=%0d want=8", n_words);
    end
    for (int i = 0; i < 8 && i < n_words; i++) begin
      checks++;
      if (got_addr[i] !== 3'(i) ||
          got_data[i] !== 16'h1000 + 16'(i) ||
          got_cyc[i] != 2 + 2 * i) begin
        failures++;
        $display("FAIL full_word[%0d] got=%0d/%h@%0d want=%0d/%h@%0d",
                 i, got_addr[i], got_data[i], got_cyc[i],
                 i, 16'h1000 + 16'(i), 2 + 2 * i);
      end
    end
    checks++;
    if (n_done != 1 || done_cyc != 17) begin
      failures++;
      $display("FAIL full_done got=%0d@%0d want=1@17", n_done, done_cyc);
    end
    checks++;
    if (busy_cnt != 17) begin
      failures++;
      $display("FAIL full_busy got=%0d want=17", busy_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_hooks();
    run_dump(3, 5);
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (hold_valid[s] !== 1'b1 || hold_addr[s] !== 3'd3 ||
          hold_data[s] !== 16'h1003) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%h want=1/3/1003",
                 s, hold_valid[s], hold_addr[s], hold_data[s]);
      end
    end
    checks++;
    if (n_words != 8 || got_cyc[3] != 13 || got_data[3] !== 16'h1003) begin
      failures++;
      $display("FAIL bp_word3 got=%0d words %h@%0d want=8 1003@13",
               n_words, got_data[3], got_cyc[3]);
    end
    checks++;
    if (n_done != 1 || done_cyc != 22) begin
      failures++;
      $display("FAIL bp_done got=%0d@%0d want=1@22", n_done, done_cyc);
    end
  endtask

  task automatic test_writes_during_dump();
    clear_hooks();
    wr_cyc[0] = 5;
    wr_a[0]   = 3'd2;
    wr_d[0]   = 16'hBEEF;
    wr_cyc[1] = 6;
    wr_a[1]   = 3'd5;
    wr_d[1]   = 16'hCAFE;
    run_dump(-1, 0);
    checks++;
    if (n_words != 8 || got_data[2] !== 16'hBEEF) begin
      failures++;
      $display("FAIL wt_word2 got=%h (%0d words) want=beef",
               got_data[2], n_words);
    end
    checks++;
    if (got_data[5] !== 16'hCAFE) begin
      failures++;
      $display("FAIL wd_word5 got=%h want=cafe", got_data[5]);
    end
    checks++;
    if (got_data[4] !== 16'h1004 || got_data[6] !== 16'h1006) begin
      failures++;
      $display("FAIL wd_neigh got=%h/%h want=1004/1006",
               got_data[4], got_data[6]);
    end
    address = 3'd2;
    #1;
    checks++;
    if (out !== 16'hBEEF) begin
      failures++;
      $display("FAIL wd_mem2 got=%h want=beef", out);
    end
  endtask

  task automatic test_ignored_start();
    clear_hooks();
    extra_start = 6;
    run_dump(-1, 0);
    checks++;
    if (n_words != 8 || n_done != 1 || done_cyc != 17) begin
      failures++;
      $display("FAIL ign_start got=%0d words %0d done@%0d want=8 1@17",
               n_words, n_done, done_cyc);
    end
    checks++;
    if (busy_cnt != 17) begin
      failures++;
      $display("FAIL ign_busy got=%0d want=17", busy_cnt);
    end
  endtask

  task automatic test_reset_mid_dump();
    clear_hooks();
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    checks++;
    if (dump_valid !== 1'b1 || dump_addr !== 3'd4) begin
      failures++;
      $display("FAIL rm_pre got=%b/%0d want=1/4", dump_valid, dump_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      failures++;
      $display("FAIL rm_flags got=%b want=000",
               {dump_valid, dump_busy, dump_done});
    end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      checks++;
      if (out !== 16'h0) begin
        failures++;
        $display("FAIL rm_out[%0d] got=%h want=0000", i, out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_dump(-1, 0);
    checks++;
    if (n_words != 8 || n_done != 1) begin
      failures++;
      $display("FAIL rm_redump got=%0d words %0d done want=8 1",
               n_words, n_done);
    end
    for (int i = 0; i < 8 && i < n_words; i++) begin
      checks++;
      if (got_data[i] !== 16'h0 || got_addr[i] !== 3'(i)) begin
        failures++;
        $display("FAIL rm_word[%0d] got=%0d/%h want=%0d/0000",
                 i, got_addr[i], got_data[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_full_dump();
    test_backpressure();
    test_writes_during_dump();
    test_ignored_start();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
